// File: rtl/nv_nvdla_sdp_mrdma_ig_req_gen.sv
// SDP MRDMA ingress read-request generator.
// Walks a cube of surfaces x lines x atoms and emits one read request per
// burst of at most MAX_ATOMS 32-byte atoms, with a valid/ready handshake.
module nv_nvdla_sdp_mrdma_ig_req_gen #(
    parameter int MAX_ATOMS = 8
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        op_load,
    input  logic [63:0] reg_base_addr,
    input  logic [12:0] reg_width,
    input  logic [12:0] reg_height,
    input  logic [12:0] reg_surf_num,
    input  logic [31:0] reg_line_stride,
    input  logic [31:0] reg_surf_stride,
    output logic        dma_rd_req_vld,
    input  logic        dma_rd_req_rdy,
    output logic [78:0] dma_rd_req_pd,
    output logic        busy,
    output logic        op_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [13:0] LP_MAX_ATOMS = 14'(MAX_ATOMS);

    state_e      r_state;
    state_e      w_state_nxt;

    // Shadow copies of the op configuration, frozen at op_load.
    logic [12:0] r_width;
    logic [12:0] r_height;
    logic [12:0] r_surf_num;
    logic [31:0] r_line_stride;
    logic [31:0] r_surf_stride;

    // Walk position and address accumulators.
    logic [12:0] r_x_cnt;
    logic [12:0] r_h_cnt;
    logic [12:0] r_s_cnt;
    logic [63:0] r_line_base;
    logic [63:0] r_surf_base;

    logic        w_vld;
    logic        w_accept;
    logic [13:0] w_line_len;
    logic [13:0] w_remain;
    logic [13:0] w_atoms;
    logic [13:0] w_atoms_m1;
    logic [13:0] w_x_next;
    logic        w_line_end;
    logic        w_surf_end;
    logic        w_last_req;
    logic [63:0] w_addr;

    // Burst sizing and address of the request currently presented.
    assign w_line_len = {1'b0, r_width} + 14'd1;
    assign w_remain   = w_line_len - {1'b0, r_x_cnt};
    assign w_atoms    = (w_remain > LP_MAX_ATOMS) ? LP_MAX_ATOMS : w_remain;
    assign w_atoms_m1 = w_atoms - 14'd1;
    assign w_x_next   = {1'b0, r_x_cnt} + w_atoms;
    assign w_line_end = (w_x_next == w_line_len);
    assign w_surf_end = w_line_end && (r_h_cnt == r_height);
    assign w_last_req = w_surf_end && (r_s_cnt == r_surf_num);
    assign w_addr     = r_surf_base + r_line_base + {46'd0, r_x_cnt, 5'd0};
    assign w_accept   = w_vld & dma_rd_req_rdy;

    // Payload is derived from registered counters only, so it stays stable
    // while the request is stalled; it reads as zero whenever no request is up.
    assign dma_rd_req_vld = w_vld;
    assign dma_rd_req_pd  = w_vld ? {1'b0, w_atoms_m1, w_addr} : 79'd0;
    assign busy           = (r_state != ST_IDLE);

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        w_state_nxt = r_state;
        w_vld       = 1'b0;
        op_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_load) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_vld = 1'b1;
                if (dma_rd_req_rdy && w_last_req) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                op_done     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Configuration capture and cube walk: load on start, advance on accept.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_width       <= 13'd0;
            r_height      <= 13'd0;
            r_surf_num    <= 13'd0;
            r_line_stride <= 32'd0;
            r_surf_stride <= 32'd0;
            r_x_cnt       <= 13'd0;
            r_h_cnt       <= 13'd0;
            r_s_cnt       <= 13'd0;
            r_line_base   <= 64'd0;
            r_surf_base   <= 64'd0;
        end else if ((r_state == ST_IDLE) && op_load) begin
            r_width       <= reg_width;
            r_height      <= reg_height;
            r_surf_num    <= reg_surf_num;
            r_line_stride <= reg_line_stride;
            r_surf_stride <= reg_surf_stride;
            r_x_cnt       <= 13'd0;
            r_h_cnt       <= 13'd0;
            r_s_cnt       <= 13'd0;
            r_line_base   <= 64'd0;
            r_surf_base   <= reg_base_addr;
        end else if (w_accept) begin
            if (!w_line_end) begin
                r_x_cnt <= w_x_next[12:0];
            end else begin
                r_x_cnt <= 13'd0;
                if (!w_surf_end) begin
                    r_h_cnt     <= r_h_cnt + 13'd1;
                    r_line_base <= r_line_base + {32'd0, r_line_stride};
                end else begin
                    // Line base restarts each surface; the surface stride is absolute.
                    r_h_cnt     <= 13'd0;
                    r_line_base <= 64'd0;
                    if (!w_last_req) begin
                        r_s_cnt     <= r_s_cnt + 13'd1;
                        r_surf_base <= r_surf_base + {32'd0, r_surf_stride};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_ig_req_gen.sv
// Scoreboard bench for the MRDMA ingress request generator: a cube-walk model
// queues expected requests at op start; a negedge monitor checks every cycle.
module tb_nv_nvdla_sdp_mrdma_ig_req_gen;

    localparam int MAX_ATOMS = 8;

    logic        clk;
    logic        rstn;
    logic        op_load;
    logic [63:0] base_addr;
    logic [12:0] width;
    logic [12:0] height;
    logic [12:0] surf_num;
    logic [31:0] line_stride;
    logic [31:0] surf_stride;
    logic        vld;
    logic        rdy;
    logic [78:0] pd;
    logic        busy;
    logic        op_done;

    typedef struct packed {
        logic [78:0] pd;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_done = 1'b0;
    logic        stall_prev = 1'b0;
    logic [78:0] prev_pd = '0;
    logic        rdy_manual = 1'b1;
    int          rdy_pct = 70;

    nv_nvdla_sdp_mrdma_ig_req_gen #(.MAX_ATOMS(MAX_ATOMS)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .op_load        (op_load),
        .reg_base_addr  (base_addr),
        .reg_width      (width),
        .reg_height     (height),
        .reg_surf_num   (surf_num),
        .reg_line_stride(line_stride),
        .reg_surf_stride(surf_stride),
        .dma_rd_req_vld (vld),
        .dma_rd_req_rdy (rdy),
        .dma_rd_req_pd  (pd),
        .busy           (busy),
        .op_done        (op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: enumerate every burst of the cube with plain arithmetic.
    task automatic push_op(input logic [63:0] b, input int w, input int h, input int s,
                           input logic [31:0] ls, input logic [31:0] ss);
        exp_t e;
        int   a;
        for (int si = 0; si <= s; si++) begin
            for (int hi = 0; hi <= h; hi++) begin
                for (int x = 0; x <= w; x += MAX_ATOMS) begin
                    a = (w + 1 - x < MAX_ATOMS) ? (w + 1 - x) : MAX_ATOMS;
                    e.pd[78:64] = 15'(a - 1);
                    e.pd[63:0]  = b + 64'(si) * {32'd0, ss} + 64'(hi) * {32'd0, ls}
                                  + 64'(x) * 64'd32;
                    e.last      = (si == s) && (hi == h) && (x + a > w);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic randomize_regs();
        base_addr   = {$urandom, $urandom} & ~64'h1F;
        width       = 13'($urandom_range(0, 8191));
        height      = 13'($urandom_range(0, 8191));
        surf_num    = 13'($urandom_range(0, 8191));
        line_stride = $urandom & ~32'h1F;
        surf_stride = $urandom & ~32'h1F;
    endtask

    // Start an op from IDLE; returns just after the capturing edge.
    task automatic launch(input logic [63:0] b, input int w, input int h, input int s,
                          input logic [31:0] ls, input logic [31:0] ss);
        @(posedge clk); #1;
        op_load     = 1'b1;
        base_addr   = b;
        width       = 13'(w);
        height      = 13'(h);
        surf_num    = 13'(s);
        line_stride = ls;
        surf_stride = ss;
        @(posedge clk); #1;
        op_load = 1'b0;
        push_op(b, w, h, s, ls, ss);
    endtask

    // Wait for the op to drain; optionally scramble registers and pulse op_load while busy.
    task automatic wait_idle(input int budget, input bit disturb);
        int cyc = 0;
        while (exp_q.size() > 0 || exp_done) begin
            @(posedge clk); #1;
            op_load = 1'b0;
            if (disturb) begin
                randomize_regs();
                if (exp_q.size() > 1 && $urandom_range(0, 3) == 0) op_load = 1'b1;
            end
            cyc++;
            if (cyc > budget) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout: %0d requests still pending after %0d cycles", exp_q.size(), budget);
                exp_q.delete();
                exp_done = 1'b0;
            end
        end
        op_load = 1'b0;
    endtask

    // Ready driver: random acceptance unless the sequence holds it manually.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rdy_manual) rdy = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Monitor: one check pass per cycle, on the falling edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (exp_done) begin
                check("op_done_pulse", {127'd0, op_done}, 128'd1);
                check("busy_in_done", {127'd0, busy}, 128'd1);
                check("vld_in_done", {127'd0, vld}, 128'd0);
                exp_done = 1'b0;
            end else begin
                check("op_done_quiet", {127'd0, op_done}, 128'd0);
                check("vld", {127'd0, vld}, {127'd0, exp_q.size() > 0});
                check("busy", {127'd0, busy}, {127'd0, exp_q.size() > 0});
            end
            if (vld && exp_q.size() > 0) begin
                check("pd", {49'd0, pd}, {49'd0, exp_q[0].pd});
                if (stall_prev) check("pd_stable", {49'd0, pd}, {49'd0, prev_pd});
                if (rdy) begin
                    if (exp_q[0].last) exp_done = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = vld && !rdy;
            prev_pd    = pd;
        end
    end

    initial begin
        rstn        = 1'b0;
        op_load     = 1'b0;
        rdy         = 1'b0;
        base_addr   = '0;
        width       = '0;
        height      = '0;
        surf_num    = '0;
        line_stride = '0;
        surf_stride = '0;
        #12;
        check("rst_vld", {127'd0, vld}, 128'd0);
        check("rst_pd", {49'd0, pd}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_op_done", {127'd0, op_done}, 128'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single atom.
        rdy = 1'b1;
        launch(64'h1000, 0, 0, 0, 32'h0, 32'h0);
        wait_idle(50, 1'b0);

        // Line split into 8+8+4 atoms.
        launch(64'h0, 19, 0, 0, 32'h0, 32'h0);
        wait_idle(50, 1'b0);

        // 3-D walk.
        launch(64'h0, 3, 1, 1, 32'h400, 32'h10000);
        wait_idle(50, 1'b0);

        // Backpressure: ready held low for 5 cycles with a request up.
        rdy = 1'b0;
        launch(64'h0, 3, 1, 1, 32'h400, 32'h10000);
        repeat (5) @(posedge clk);
        #1 rdy = 1'b1;
        wait_idle(50, 1'b0);

        // Address wrap, with op_load pulses and register churn while busy.
        launch(64'hFFFF_FFFF_FFFF_FFE0, 1, 1, 0, 32'h20, 32'h0);
        wait_idle(50, 1'b1);
        launch(64'hFFFF_FFFF_FFFF_FFE0, 9, 0, 0, 32'h0, 32'h0);
        wait_idle(50, 1'b1);

        // Reset after two of three accepts, then a fresh op.
        rdy = 1'b1;
        launch(64'h2000, 19, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        check("pending_before_reset", 128'(exp_q.size()), 128'd1);
        #2 rstn = 1'b0;
        #1;
        check("reset_vld", {127'd0, vld}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        exp_q.delete();
        exp_done   = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("reset_no_done", {127'd0, op_done}, 128'd0);
        launch(64'h2000, 19, 0, 0, 32'h0, 32'h0);
        wait_idle(50, 1'b0);

        // Randomized ops under random backpressure.
        rdy_manual = 1'b0;
        for (int n = 0; n < 25; n++) begin
            launch({$urandom, $urandom} & ~64'h1F, $urandom_range(0, 20), $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom & ~32'h1F, $urandom & ~32'h1F);
            wait_idle(1000, 1'b1);
        end
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
